merge_c2h: RTL

- C2H-direction counterpart of the H2C partitioner.
- After the column processors finish, it drains the per-column result FIFOs in ascending column order and serialises them onto the XDMA C2H AXI4-Stream.
- Each column contributes one header beat carrying its beat count, followed by that many data beats.
- tlast marks the final beat of the whole transfer.

---
 rtl/merge_c2h_pkg.sv | 26 ++
 rtl/merge_c2h_if.sv | 27 ++
 rtl/merge_c2h_out_reg.sv | 49 ++++
 rtl/merge_c2h.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/merge_c2h_pkg.sv
// Shared definitions for the C2H merge block: FSM encoding and the column
// header layout (the H2C partitioner uses the same header format).
package merge_c2h_pkg;

    // Merge sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEL       = 3'd1,
        ST_COL_HDR   = 3'd2,
        ST_COL_DATA  = 3'd3,
        ST_WAIT_LAST = 3'd4,
        ST_DONE      = 3'd5
    } merge_state_e;

    // Column header word: the data-beat count sits in the low bits.
    localparam int COL_HDR_LEN_LSB = 0;
    localparam int COL_HDR_LEN_W   = 16;

    // Beat count still owed after one more data beat is forwarded.
    function automatic logic [COL_HDR_LEN_W-1:0] cnt_after_beat(
        input logic [COL_HDR_LEN_W-1:0] cnt
    );
        return cnt - COL_HDR_LEN_W'(1);
    endfunction

endpackage

// File: rtl/merge_c2h_if.sv
// AXI4-Stream bundle for the XDMA C2H direction.
interface merge_c2h_if #(
    parameter int DATA_WIDTH      = 128,
    parameter int BYTE_BIT_ENABLE = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0]      tdata;
    logic [BYTE_BIT_ENABLE-1:0] tkeep;
    logic                       tlast;
    logic                       tvalid;
    logic                       tready;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/merge_c2h_out_reg.sv
// Single-stage AXIS output register for the C2H merge. A new beat may be
// loaded when the register is empty or its current beat is being taken this
// cycle; otherwise the held beat stays stable until the sink accepts it.
module c2h_out_reg #(
    parameter int DATA_WIDTH      = 128,
    parameter int BYTE_BIT_ENABLE = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  last_i,
    output logic                  can_load_o,
    output logic                  last_xfer_o,
    merge_c2h_if.master           axis
);

    logic                  valid_q;
    logic                  last_q;
    logic [DATA_WIDTH-1:0] data_q;

    // Output beat register: load a new beat, drain on acceptance, else hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            last_q  <= last_i;
            data_q  <= data_i;
        end else if (axis.tready) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_q;
        end
    end

    assign axis.tdata  = data_q;
    assign axis.tlast  = last_q;
    assign axis.tvalid = valid_q;
    assign axis.tkeep  = {BYTE_BIT_ENABLE{1'b1}};

    // Room for a new beat: register empty, or the held beat leaves this cycle.
    assign can_load_o  = !valid_q || axis.tready;
    // Final beat of the merge is being accepted this cycle.
    assign last_xfer_o = valid_q && axis.tready && last_q;

endmodule

// File: rtl/merge_c2h.sv
// C2H merge: drains enabled per-column result FIFOs in ascending column
// order onto the C2H stream. Each column sends its header beat (carrying the
// data-beat count N) then N data beats; tlast flags the final beat overall.
module merge_c2h
    import merge_c2h_pkg::*;
#(
    parameter int DATA_WIDTH      = 128,
    parameter int BYTE_BIT_ENABLE = DATA_WIDTH / 8,
    parameter int COL_MAX_SIZE    = 4
) (
    input  logic                               user_clk,
    input  logic                               user_rst,
    input  logic                               start,
    input  logic [COL_MAX_SIZE-1:0]            col_enable,
    input  logic [COL_MAX_SIZE*DATA_WIDTH-1:0] result_fifo_dout,
    input  logic [COL_MAX_SIZE-1:0]            result_fifo_empty,
    output logic [COL_MAX_SIZE-1:0]            result_fifo_rd_en,
    merge_c2h_if.master                        m_axis_c2h,
    output logic                               busy,
    output logic                               merge_done
);

    localparam int COL_W = (COL_MAX_SIZE > 1) ? $clog2(COL_MAX_SIZE) : 1;
    localparam logic [COL_MAX_SIZE-1:0] COL_ONE = COL_MAX_SIZE'(1);

    merge_state_e               state_q;
    logic [COL_MAX_SIZE-1:0]    pend_q;
    logic [COL_W-1:0]           col_q;
    logic [COL_HDR_LEN_W-1:0]   cnt_q;
    logic                       busy_q;
    logic                       done_q;

    logic [COL_W-1:0]           low_idx_s;
    logic [DATA_WIDTH-1:0]      sel_dout_s;
    logic                       sel_empty_s;
    logic [COL_HDR_LEN_W-1:0]   hdr_len_s;
    logic                       last_col_s;
    logic                       fetch_ok_s;
    logic                       beat_last_s;
    logic                       load_s;
    logic                       can_load_s;
    logic                       last_xfer_s;

    // Lowest pending column: scan downwards so the lowest set bit wins.
    always_comb begin
        low_idx_s = '0;
        for (int i = COL_MAX_SIZE - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                low_idx_s = COL_W'(i);
            end else begin
                low_idx_s = low_idx_s;
            end
        end
    end

    assign sel_dout_s = result_fifo_dout[int'(col_q) * DATA_WIDTH +: DATA_WIDTH];

    // Fetch/load decision for the current column and the tlast flag of the beat.
    always_comb begin
        sel_empty_s       = result_fifo_empty[col_q];
        hdr_len_s         = sel_dout_s[COL_HDR_LEN_LSB +: COL_HDR_LEN_W];
        last_col_s        = (pend_q == '0);
        fetch_ok_s        = 1'b0;
        beat_last_s       = 1'b0;
        case (state_q)
            ST_COL_HDR: begin
                fetch_ok_s  = !sel_empty_s;
                beat_last_s = last_col_s && (hdr_len_s == '0);
            end
            ST_COL_DATA: begin
                fetch_ok_s  = !sel_empty_s;
                beat_last_s = last_col_s && (cnt_q == COL_HDR_LEN_W'(1));
            end
            default: begin
                fetch_ok_s  = 1'b0;
                beat_last_s = 1'b0;
            end
        endcase
        load_s = can_load_s && fetch_ok_s;
        if (load_s) begin
            result_fifo_rd_en = COL_ONE << col_q;
        end else begin
            result_fifo_rd_en = '0;
        end
    end

    // Merge sequencer: column selection, header/data counting, completion pulse.
    always_ff @(posedge user_clk or negedge user_rst) begin
        if (!user_rst) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        pend_q  <= col_enable;
                        busy_q  <= 1'b1;
                        state_q <= (col_enable != '0) ? ST_SEL : ST_DONE;
                    end
                end
                ST_SEL: begin
                    col_q   <= low_idx_s;
                    pend_q  <= pend_q & ~(COL_ONE << low_idx_s);
                    state_q <= ST_COL_HDR;
                end
                ST_COL_HDR: begin
                    if (load_s) begin
                        cnt_q <= hdr_len_s;
                        if (hdr_len_s == '0) begin
                            state_q <= last_col_s ? ST_WAIT_LAST : ST_SEL;
                        end else begin
                            state_q <= ST_COL_DATA;
                        end
                    end
                end
                ST_COL_DATA: begin
                    if (load_s) begin
                        cnt_q <= cnt_after_beat(cnt_q);
                        if (cnt_q == COL_HDR_LEN_W'(1)) begin
                            state_q <= last_col_s ? ST_WAIT_LAST : ST_SEL;
                        end
                    end
                end
                ST_WAIT_LAST: begin
                    if (last_xfer_s) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign merge_done = done_q;

    c2h_out_reg #(
        .DATA_WIDTH      (DATA_WIDTH),
        .BYTE_BIT_ENABLE (BYTE_BIT_ENABLE)
    ) u_out_reg (
        .clk_i       (user_clk),
        .rst_ni      (user_rst),
        .load_i      (load_s),
        .data_i      (sel_dout_s),
        .last_i      (beat_last_s),
        .can_load_o  (can_load_s),
        .last_xfer_o (last_xfer_s),
        .axis        (m_axis_c2h)
    );

endmodule
